// File: rtl/syrup_channel_fifo_if.sv
// Channel link between a syrup out-/in-channel port pair and the FIFO that
// backs it.
//   syrup_d   : write data, driven by the producer (out-channel)
//   syrup_we  : write request, driven by the producer
//   syrup_re  : read (pop) request, driven by the consumer (in-channel)
//   syrup_q   : head-of-queue data, driven by the FIFO
// Modports:
//   master : the user-domain side (drives d/we/re, observes q)
//   slave  : the FIFO side (observes d/we/re, drives q)
interface syrup_channel_fifo_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] syrup_d;
    logic                  syrup_we;
    logic [DATA_WIDTH-1:0] syrup_q;
    logic                  syrup_re;

    modport master (
        output syrup_d,
        output syrup_we,
        output syrup_re,
        input  syrup_q
    );

    modport slave (
        input  syrup_d,
        input  syrup_we,
        input  syrup_re,
        output syrup_q
    );
endinterface

// File: rtl/syrup_channel_fifo.sv
// syrup_channel_fifo: first-word-fall-through backing store for a syrup
// channel pair, depth 2**ADDR_WIDTH.
//   CLK       : sole clock, rising edge
//   RST       : synchronous active-high reset (pointers, count, flags)
//   ch        : channel link (slave side): syrup_d/syrup_we in,
//               syrup_re in, syrup_q out (combinational head of queue)
//   full      : count == DEPTH
//   empty     : count == 0
//   count     : current occupancy, 0..DEPTH
//   stall     : combinational; a request in this cycle is being refused
//   overflow  : sticky; a write was refused since reset
//   underflow : sticky; a read was refused since reset
module syrup_channel_fifo #(
    parameter string       DOMAIN     = "undefined",
    parameter int          ID         = 0,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    syrup_channel_fifo_if.slave     ch,
    output logic                    full,
    output logic                    empty,
    output logic [ADDR_WIDTH:0]     count,
    output logic                    stall,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wp;
    logic [ADDR_WIDTH-1:0] rp;
    logic                  wr_ok;
    logic                  rd_ok;

    // Occupancy decode from the registered count.
    always_comb begin
        full  = (count == CW'(DEPTH));
        empty = (count == '0);
    end

    // Acceptance: a write at full is allowed only alongside a read that
    // frees a slot; a read at empty is always refused (no bypass).
    always_comb begin
        wr_ok = ch.syrup_we & (~full | ch.syrup_re);
        rd_ok = ch.syrup_re & ~empty;
        stall = (ch.syrup_we & ~wr_ok) | (ch.syrup_re & ~rd_ok);
    end

    // Head of queue, forced to zero while nothing is queued.
    always_comb begin
        ch.syrup_q = empty ? '0 : mem[rp];
    end

    // Storage array; contents survive reset, only the pointers clear.
    always_ff @(posedge CLK) begin
        if (!RST && wr_ok) begin
            mem[wp] <= ch.syrup_d;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (wr_ok) begin
                wp <= wp + ADDR_WIDTH'(1);
            end
            if (rd_ok) begin
                rp <= rp + ADDR_WIDTH'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags, set the cycle after a refused request.
    always_ff @(posedge CLK) begin
        if (RST) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ch.syrup_we && !wr_ok) begin
                overflow <= 1'b1;
            end
            if (ch.syrup_re && !rd_ok) begin
                underflow <= 1'b1;
            end
        end
    end

    // Occupancy must stay within 0..DEPTH and full/empty are exclusive.
    a_count_range : assert property (
        @(posedge CLK) disable iff (RST) count <= CW'(DEPTH)
    ) else $error("syrup_channel_fifo %s[%0d]: count out of range", DOMAIN, ID);

    a_full_empty : assert property (
        @(posedge CLK) disable iff (RST) !(full && empty)
    ) else $error("syrup_channel_fifo %s[%0d]: full and empty together", DOMAIN, ID);

endmodule

// File: tb/tb_syrup_channel_fifo.sv
// Directed bench for syrup_channel_fifo with DEPTH=4, DATA_WIDTH=32.
module tb_syrup_channel_fifo;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 2;

    logic          clk;
    logic          rst;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          stall;
    logic          overflow;
    logic          underflow;

    int checks = 0;
    int errors = 0;

    syrup_channel_fifo_if #(.DATA_WIDTH(DW)) ch ();

    syrup_channel_fifo #(
        .DOMAIN     ("tb"),
        .ID         (0),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .ch        (ch.slave),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .stall     (stall),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle just past it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ch.syrup_we = 1'b0;
        ch.syrup_re = 1'b0;
        ch.syrup_d  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (ch.syrup_q !== 32'h0) begin errors++; $display("FAIL reset_q got %h exp 0", ch.syrup_q); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++; $display("FAIL reset_flags got ovf=%b unf=%b exp 0/0", overflow, underflow);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 4; i++) begin
            ch.syrup_we = 1'b1;
            ch.syrup_d  = 32'hA0 + 32'(i);
            #1;
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fill_stall[%0d] got %b exp 0", i, stall); end
            cyc();
            checks++; if (ch.syrup_q !== 32'hA0) begin errors++; $display("FAIL fill_head[%0d] got %h exp a0", i, ch.syrup_q); end
        end
        idle();
        checks++; if (full !== 1'b1 || count !== 3'd4) begin
            errors++; $display("FAIL fill_full got full=%b count=%0d exp 1/4", full, count);
        end
        for (int i = 0; i < 4; i++) begin
            ch.syrup_re = 1'b1;
            #1;
            checks++; if (ch.syrup_q !== 32'hA0 + 32'(i)) begin
                errors++; $display("FAIL drain_q[%0d] got %h exp %h", i, ch.syrup_q, 32'hA0 + 32'(i));
            end
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL drain_stall[%0d] got %b exp 0", i, stall); end
            cyc();
        end
        idle();
        checks++; if (empty !== 1'b1 || count !== 3'd0 || ch.syrup_q !== 32'h0) begin
            errors++; $display("FAIL drain_empty got empty=%b count=%0d q=%h exp 1/0/0", empty, count, ch.syrup_q);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_seq [4];
        for (int i = 0; i < 4; i++) begin
            ch.syrup_we = 1'b1;
            ch.syrup_d  = 32'hE0 + 32'(i);
            cyc();
        end
        // Lone write at full: refused and dropped.
        ch.syrup_we = 1'b1;
        ch.syrup_d  = 32'hFF;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ovf_stall got %b exp 1", stall); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", overflow); end
        cyc();
        idle();
        checks++; if (overflow !== 1'b1 || count !== 3'd4) begin
            errors++; $display("FAIL ovf_flag got ovf=%b count=%0d exp 1/4", overflow, count);
        end
        // Write with a simultaneous read at full: accepted.
        ch.syrup_we = 1'b1;
        ch.syrup_re = 1'b1;
        ch.syrup_d  = 32'hB0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL wr_rd_full_stall got %b exp 0", stall); end
        checks++; if (ch.syrup_q !== 32'hE0) begin errors++; $display("FAIL wr_rd_full_q got %h exp e0", ch.syrup_q); end
        cyc();
        idle();
        checks++; if (count !== 3'd4 || full !== 1'b1) begin
            errors++; $display("FAIL wr_rd_full_count got count=%0d full=%b exp 4/1", count, full);
        end
        exp_seq[0] = 32'hE1; exp_seq[1] = 32'hE2; exp_seq[2] = 32'hE3; exp_seq[3] = 32'hB0;
        for (int i = 0; i < 4; i++) begin
            ch.syrup_re = 1'b1;
            #1;
            checks++; if (ch.syrup_q !== exp_seq[i]) begin
                errors++; $display("FAIL ovf_drain_q[%0d] got %h exp %h", i, ch.syrup_q, exp_seq[i]);
            end
            cyc();
        end
        idle();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_drain_empty got %b exp 1", empty); end
    endtask

    task automatic test_underflow();
        ch.syrup_we = 1'b1;
        ch.syrup_re = 1'b1;
        ch.syrup_d  = 32'hC0;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL unf_stall got %b exp 1", stall); end
        checks++; if (ch.syrup_q !== 32'h0) begin errors++; $display("FAIL unf_no_bypass got %h exp 0", ch.syrup_q); end
        cyc();
        idle();
        checks++; if (underflow !== 1'b1 || count !== 3'd1) begin
            errors++; $display("FAIL unf_flag got unf=%b count=%0d exp 1/1", underflow, count);
        end
        checks++; if (ch.syrup_q !== 32'hC0 || empty !== 1'b0) begin
            errors++; $display("FAIL unf_q got q=%h empty=%b exp c0/0", ch.syrup_q, empty);
        end
        ch.syrup_re = 1'b1;
        cyc();
        idle();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL unf_drain got %b exp 1", empty); end
    endtask

    // Pointers are mid-array here, so six words exercise the wrap.
    task automatic test_wrap();
        ch.syrup_we = 1'b1;
        ch.syrup_d  = 32'h10;
        cyc();
        for (int i = 1; i < 6; i++) begin
            ch.syrup_we = 1'b1;
            ch.syrup_re = 1'b1;
            ch.syrup_d  = 32'h10 + 32'(i);
            #1;
            checks++; if (stall !== 1'b0 || ch.syrup_q !== 32'h10 + 32'(i - 1)) begin
                errors++; $display("FAIL wrap_pre[%0d] got stall=%b q=%h exp 0/%h", i, stall, ch.syrup_q, 32'h10 + 32'(i - 1));
            end
            cyc();
            checks++; if (ch.syrup_q !== 32'h10 + 32'(i) || count !== 3'd1) begin
                errors++; $display("FAIL wrap_post[%0d] got q=%h count=%0d exp %h/1", i, ch.syrup_q, count, 32'h10 + 32'(i));
            end
        end
        idle();
        ch.syrup_re = 1'b1;
        cyc();
        idle();
        checks++; if (empty !== 1'b1 || count !== 3'd0) begin
            errors++; $display("FAIL wrap_end got empty=%b count=%0d exp 1/0", empty, count);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            ch.syrup_we = 1'b1;
            ch.syrup_d  = 32'hD1 + 32'(i);
            cyc();
        end
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL mid_prefill got %0d exp 3", count); end
        rst = 1'b1;
        ch.syrup_we = 1'b1;
        ch.syrup_d  = 32'h77;
        cyc();
        rst = 1'b0;
        idle();
        checks++; if (count !== 3'd0 || empty !== 1'b1 || ch.syrup_q !== 32'h0) begin
            errors++; $display("FAIL mid_reset got count=%0d empty=%b q=%h exp 0/1/0", count, empty, ch.syrup_q);
        end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++; $display("FAIL mid_flags got ovf=%b unf=%b exp 0/0", overflow, underflow);
        end
        ch.syrup_we = 1'b1;
        ch.syrup_d  = 32'hD0;
        cyc();
        idle();
        checks++; if (ch.syrup_q !== 32'hD0 || count !== 3'd1) begin
            errors++; $display("FAIL mid_rewrite got q=%h count=%0d exp d0/1", ch.syrup_q, count);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
